// File: rtl/llr_quantizer.sv
// Soft-sample to LLR front end: per-frame rounding right shift, symmetric saturation,
// re-framing to CODE_LENGTH beats, with an output register plus skid register.
//
// state | meaning
// FIRST | beat counter at 0, waiting for beat 0; shift is latched on its acceptance
// BODY  | beat counter 1..CODE_LENGTH-1, frame in progress
module llr_quantizer #(
    parameter int CODE_LENGTH    = 1024,
    parameter int IN_DATA_WIDTH  = 16,
    parameter int LLR_DATA_WIDTH = 8,
    parameter int SHIFT_WIDTH    = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [SHIFT_WIDTH-1:0]            shift,
    input  logic [IN_DATA_WIDTH-1:0]          s_axi_tdata,
    input  logic                              s_axi_tvalid,
    input  logic                              s_axi_tlast,
    output logic                              s_axi_tready,
    output logic [LLR_DATA_WIDTH-1:0]         m_axi_tdata,
    output logic                              m_axi_tvalid,
    output logic                              m_axi_tlast,
    input  logic                              m_axi_tready,
    output logic                              frame_error,
    output logic                              error_sticky,
    output logic [$clog2(CODE_LENGTH):0]      sat_count
);
    localparam int CW   = $clog2(CODE_LENGTH);
    localparam int SCW  = CW + 1;
    localparam int LMAX = 2 ** (LLR_DATA_WIDTH - 1) - 1;

    typedef enum logic {FIRST, BODY} state_t;

    state_t                          state, state_next;
    logic [CW-1:0]                   cnt;
    logic [SHIFT_WIDTH-1:0]          sh_reg, sh;
    logic [SCW-1:0]                  sat_run;

    logic                            accept, at_last_cnt, beat_last, frame_end, frame_bad;
    logic signed [IN_DATA_WIDTH:0]   x_ext, rnd, sum, r;
    logic signed [IN_DATA_WIDTH:0]   lmax_w;
    logic [LLR_DATA_WIDTH-1:0]       q;
    logic                            sat;

    logic [LLR_DATA_WIDTH-1:0]       skid_data;
    logic                            skid_last, skid_valid;

    assign accept      = s_axi_tvalid & s_axi_tready;
    assign at_last_cnt = (cnt == CW'(CODE_LENGTH - 1));
    assign beat_last   = s_axi_tlast | at_last_cnt;
    assign frame_end   = accept & beat_last;
    // early tlast or missing tlast are both "tlast disagrees with the counter"
    assign frame_bad   = accept & (s_axi_tlast ^ at_last_cnt);
    assign sh          = (state == FIRST) ? shift : sh_reg;
    assign lmax_w      = (IN_DATA_WIDTH + 1)'(LMAX);

    always_comb begin
        x_ext = {s_axi_tdata[IN_DATA_WIDTH-1], s_axi_tdata};
        rnd   = '0;
        sum   = x_ext;
        r     = x_ext;
        q     = '0;
        sat   = 1'b0;
        if (sh != '0) begin
            rnd = (IN_DATA_WIDTH + 1)'(1) << (sh - SHIFT_WIDTH'(1));
            sum = x_ext + rnd;
            r   = sum >>> sh;
        end
        if (r > lmax_w) begin
            q   = LLR_DATA_WIDTH'(LMAX);
            sat = 1'b1;
        end else if (r < -lmax_w) begin
            q   = LLR_DATA_WIDTH'(-LMAX);
            sat = 1'b1;
        end else begin
            q = r[LLR_DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FIRST;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FIRST:   if (accept && !beat_last) state_next = BODY;
            BODY:    if (frame_end)            state_next = FIRST;
            default: state_next = FIRST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            sh_reg       <= '0;
            sat_run      <= '0;
            sat_count    <= '0;
            frame_error  <= 1'b0;
            error_sticky <= 1'b0;
        end else begin
            frame_error <= frame_bad;
            if (frame_bad) error_sticky <= 1'b1;
            if (accept && state == FIRST) sh_reg <= shift;
            if (frame_end) begin
                cnt       <= '0;
                sat_count <= sat_run + SCW'(sat);
                sat_run   <= '0;
            end else if (accept) begin
                cnt     <= cnt + CW'(1);
                sat_run <= sat_run + SCW'(sat);
            end
        end
    end

    // s_axi_tready mirrors "skid empty", so a beat never arrives while the skid is full
    always_ff @(posedge clk) begin
        if (reset) begin
            m_axi_tvalid <= 1'b0;
            m_axi_tdata  <= '0;
            m_axi_tlast  <= 1'b0;
            skid_valid   <= 1'b0;
            skid_data    <= '0;
            skid_last    <= 1'b0;
            s_axi_tready <= 1'b1;
        end else if (!m_axi_tvalid || m_axi_tready) begin
            if (skid_valid) begin
                m_axi_tdata  <= skid_data;
                m_axi_tlast  <= skid_last;
                m_axi_tvalid <= 1'b1;
                skid_valid   <= 1'b0;
                s_axi_tready <= 1'b1;
            end else if (accept) begin
                m_axi_tdata  <= q;
                m_axi_tlast  <= beat_last;
                m_axi_tvalid <= 1'b1;
            end else begin
                m_axi_tvalid <= 1'b0;
            end
        end else if (accept) begin
            skid_data    <= q;
            skid_last    <= beat_last;
            skid_valid   <= 1'b1;
            s_axi_tready <= 1'b0;
        end
    end
endmodule

// File: tb/tb_llr_quantizer.sv
// Scoreboard bench for llr_quantizer: driver pushes reference-model results,
// monitor pops them on each output handshake.
module tb_llr_quantizer;
    localparam int CL = 1024;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  shift = '0;
    logic [15:0] s_axi_tdata = '0;
    logic        s_axi_tvalid = 1'b0;
    logic        s_axi_tlast = 1'b0;
    logic        s_axi_tready;
    logic [7:0]  m_axi_tdata;
    logic        m_axi_tvalid;
    logic        m_axi_tlast;
    logic        m_axi_tready = 1'b0;
    logic        frame_error;
    logic        error_sticky;
    logic [10:0] sat_count;

    llr_quantizer #(.CODE_LENGTH(CL), .IN_DATA_WIDTH(16), .LLR_DATA_WIDTH(8), .SHIFT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .shift(shift),
        .s_axi_tdata(s_axi_tdata), .s_axi_tvalid(s_axi_tvalid), .s_axi_tlast(s_axi_tlast),
        .s_axi_tready(s_axi_tready),
        .m_axi_tdata(m_axi_tdata), .m_axi_tvalid(m_axi_tvalid), .m_axi_tlast(m_axi_tlast),
        .m_axi_tready(m_axi_tready),
        .frame_error(frame_error), .error_sticky(error_sticky), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_fail = 0;
    logic [8:0] expq[$];

    // reference model state
    int  mdl_cnt = 0, mdl_sh = 0, mdl_run = 0, cur_shift = 0;
    int  exp_sat = 0;
    bit  exp_sticky = 0, bp = 0;
    bit  pend_err = 0, pend_sat_valid = 0;
    int  pend_sat_val = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int floordiv(input int a, input int b);
        int qq;
        qq = a / b;
        if ((a % b) != 0 && a < 0) qq = qq - 1;
        return qq;
    endfunction

    function automatic int quant(input int x, input int s, output bit was_sat);
        int r;
        r = (s == 0) ? x : floordiv(x + (2 ** s) / 2, 2 ** s);
        was_sat = 1'b1;
        if (r > 127)       return 127;
        else if (r < -127) return -127;
        was_sat = 1'b0;
        return r;
    endfunction

    task automatic model_accept(input int x, input bit l);
        bit s, fend;
        int qv;
        if (mdl_cnt == 0) mdl_sh = cur_shift;
        qv   = quant(x, mdl_sh, s);
        fend = l || (mdl_cnt == CL - 1);
        pend_err = fend && !(l && mdl_cnt == CL - 1);
        expq.push_back({fend, 8'(qv)});
        mdl_run += int'(s);
        if (fend) begin
            pend_sat_valid = 1'b1;
            pend_sat_val   = mdl_run;
            mdl_run = 0;
            mdl_cnt = 0;
        end else begin
            mdl_cnt++;
        end
    endtask

    task automatic check_pending();
        check("frame_error", int'(frame_error), int'(pend_err));
        if (pend_err) exp_sticky = 1'b1;
        pend_err = 1'b0;
        if (pend_sat_valid) exp_sat = pend_sat_val;
        pend_sat_valid = 1'b0;
        check("error_sticky", int'(error_sticky), int'(exp_sticky));
        check("sat_count", int'(sat_count), exp_sat);
    endtask

    task automatic step(input bit v, input int x, input bit l, output bit acc);
        @(posedge clk); #1;
        check_pending();
        s_axi_tvalid = v;
        s_axi_tdata  = x[15:0];
        s_axi_tlast  = l;
        // shift only matters on beat 0; scramble it elsewhere
        shift = (mdl_cnt == 0) ? 4'(cur_shift) : 4'($urandom_range(0, 15));
        m_axi_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        acc = v && s_axi_tready;
        if (acc) model_accept(x, l);
    endtask

    task automatic send_beat(input int x, input bit l);
        bit acc;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) step(1'b1, x, l, acc);
        if (!acc) check("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, acc);
    endtask

    function automatic int rnd16();
        logic signed [15:0] t;
        t = 16'($urandom);
        return int'(t);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        check_pending();
        reset = 1'b1;
        s_axi_tvalid = 1'b0;
        @(posedge clk); #1;
        check("rst_m_tvalid", int'(m_axi_tvalid), 0);
        check("rst_m_tdata", int'(m_axi_tdata), 0);
        check("rst_m_tlast", int'(m_axi_tlast), 0);
        check("rst_frame_error", int'(frame_error), 0);
        check("rst_error_sticky", int'(error_sticky), 0);
        check("rst_sat_count", int'(sat_count), 0);
        expq.delete();
        mdl_cnt = 0; mdl_run = 0; exp_sat = 0; exp_sticky = 1'b0;
        pend_err = 1'b0; pend_sat_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("tready_after_reset", int'(s_axi_tready), 1);
    endtask

    // monitor: pops on each output handshake and checks stability under stall
    bit         held = 1'b0;
    logic [8:0] held_v;
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!reset && m_axi_tvalid) begin
                if (held && {m_axi_tlast, m_axi_tdata} != held_v)
                    check("stall_stable", int'({m_axi_tlast, m_axi_tdata}), int'(held_v));
                if (m_axi_tready) begin
                    held = 1'b0;
                    if (expq.size() == 0) begin
                        check("unexpected_beat", int'({m_axi_tlast, m_axi_tdata}), -1);
                    end else begin
                        e = expq.pop_front();
                        check("beat_tdata", int'($signed(m_axi_tdata)), int'($signed(e[7:0])));
                        check("beat_tlast", int'(m_axi_tlast), int'(e[8]));
                    end
                end else begin
                    held   = 1'b1;
                    held_v = {m_axi_tlast, m_axi_tdata};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dir[6];
        dir = '{5, 6, -6, -7, 1000, -1000};

        repeat (2) @(posedge clk);
        #1;
        check("init_m_tvalid", int'(m_axi_tvalid), 0);
        check("init_m_tlast", int'(m_axi_tlast), 0);
        check("init_frame_error", int'(frame_error), 0);
        check("init_sat_count", int'(sat_count), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("init_tready", int'(s_axi_tready), 1);

        // ramp, shift 0, no backpressure
        bp = 1'b0; cur_shift = 0;
        for (int i = 0; i < CL; i++) send_beat(i, i == CL - 1);
        idle(4);
        check("ramp_sat_896", int'(sat_count), 896);
        check("ramp_no_error", int'(error_sticky), 0);

        // rounding / saturation, shift 2
        cur_shift = 2;
        for (int i = 0; i < CL; i++) send_beat(i < 6 ? dir[i] : rnd16(), i == CL - 1);
        idle(4);

        // ramp again under 50% backpressure
        bp = 1'b1; cur_shift = 0;
        for (int i = 0; i < CL; i++) send_beat(i, i == CL - 1);
        idle(8);

        // early tlast on beat 10, then a full frame with a new shift
        cur_shift = 3;
        for (int i = 0; i < 11; i++) send_beat(rnd16(), i == 10);
        idle(4);
        check("early_sticky", int'(error_sticky), 1);
        cur_shift = 1;
        for (int i = 0; i < CL; i++) send_beat(rnd16(), i == CL - 1);

        // missing tlast: 1030 beats, then finish the second frame properly
        bp = 1'b0; cur_shift = 4;
        for (int i = 0; i < 1030; i++) send_beat(rnd16(), 1'b0);
        cur_shift = 5;
        for (int i = 6; i < CL; i++) send_beat(rnd16(), i == CL - 1);
        idle(4);

        // reset at beat 500
        bp = 1'b1; cur_shift = 6;
        for (int i = 0; i < 500; i++) send_beat(rnd16(), 1'b0);
        do_reset();
        check("post_rst_sticky", int'(error_sticky), 0);
        check("post_rst_sat", int'(sat_count), 0);
        cur_shift = 7;
        for (int i = 0; i < CL; i++) send_beat(rnd16() >>> ($urandom_range(0, 8)), i == CL - 1);

        bp = 1'b0;
        for (int t = 0; t < 100 && expq.size() != 0; t++) idle(1);
        idle(2);
        check("queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
